// File: rtl/mem_access_unit.sv
// Load/store front end for a single-port, one-cycle-latency word memory.
// Handles byte addressing, sub-word extraction and read-modify-write stores.
module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_we,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_RESP
  } state_t;

  localparam logic [32:0] ADDR_LIMIT =
    {1'b0, 32'(MEM_WORDS)} << 2;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mdin_q, mdin_d;
  logic        mwe_q, mwe_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rfault_q, rfault_d;

  logic        fault_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_c;
  logic [31:0] merge_c;

  assign req_ready   = (state_q == S_IDLE) & rst_n;
  assign resp_valid  = rvalid_q;
  assign resp_rdata  = rdata_q;
  assign resp_fault  = rfault_q;
  assign mem_address = maddr_q;
  assign mem_data_in = mdin_q;
  assign mem_we      = mwe_q;

  assign fault_c =
    (req_size == 2'b11) |
    ((req_size == 2'b01) & req_addr[0]) |
    ((req_size == 2'b10) & (|req_addr[1:0])) |
    ({1'b0, req_addr} >= ADDR_LIMIT);

  assign lane_b = 8'(mem_data_out >> {off_q, 3'b000});
  assign lane_h = off_q[1] ? mem_data_out[31:16]
                           : mem_data_out[15:0];

  always_comb begin
    load_c = mem_data_out;
    unique case (1'b1)
      size_q == 2'b00:
        load_c = {{24{signed_q & lane_b[7]}}, lane_b};
      size_q == 2'b01:
        load_c = {{16{signed_q & lane_h[15]}}, lane_h};
      default:
        load_c = mem_data_out;
    endcase
  end

  // Untouched lanes keep the value just read back.
  always_comb begin
    merge_c = mem_data_out;
    unique case (1'b1)
      size_q == 2'b00:
        merge_c[{off_q, 3'b000} +: 8] = wdata_q[7:0];
      size_q == 2'b01:
        merge_c[{off_q[1], 4'b0000} +: 16] = wdata_q;
      default:
        merge_c = mem_data_out;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    off_d    = off_q;
    wdata_d  = wdata_q;
    maddr_d  = maddr_q;
    mdin_d   = mdin_q;
    mwe_d    = 1'b0;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rfault_d = rfault_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = req_addr[1:0];
          wdata_d  = req_wdata[15:0];
          if (fault_c) begin
            rvalid_d = 1'b1;
            rfault_d = 1'b1;
            rdata_d  = '0;
            state_d  = S_RESP;
          end else begin
            maddr_d = {2'b00, req_addr[31:2]};
            if (req_write && req_size == 2'b10) begin
              mdin_d  = req_wdata;
              mwe_d   = 1'b1;
              state_d = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (write_q) begin
          mdin_d  = merge_c;
          mwe_d   = 1'b1;
          state_d = S_WRITE;
        end else begin
          rdata_d  = load_c;
          rfault_d = 1'b0;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_WRITE: begin
        rdata_d  = '0;
        rfault_d = 1'b0;
        rvalid_d = 1'b1;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      off_q    <= 2'b00;
      wdata_q  <= '0;
      maddr_q  <= '0;
      mdin_q   <= '0;
      mwe_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rfault_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
      mwe_q    <= mwe_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rfault_q <= rfault_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, hand sequences
// and random requests against a word-array reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_we;
  logic [31:0] mem_data_out = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_we(mem_we), .mem_data_out(mem_data_out)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_we) mem[mem_address[9:0]] <= mem_data_in;
    mem_data_out <= mem[mem_address[9:0]];
  end

  int we_total = 0;
  always @(negedge clk) if (mem_we) we_total++;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic f,
                        output int lat, output int nwe,
                        output logic [31:0] ma);
    int we0;
    int guard;
    guard = 0;
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_before", 32'(req_ready), 32'd1);
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    we0 = we_total;
    @(negedge clk);
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    ma  = mem_address;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = resp_rdata;
    f  = resp_fault;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_cleared", 32'(resp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    nwe = we_total - we0;
  endtask

  // Reference: plain byte-lane arithmetic on a shadow word array.
  task automatic model(input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd,
                       output logic [31:0] rd, output logic f,
                       output int lat, output int nwe);
    int nb;
    int sh;
    logic [63:0] mask;
    logic [31:0] old;
    logic [31:0] v;
    f = (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
        (sz == 2'd2 && a[1:0] != 2'd0) || (a >= 32'd4096);
    rd = '0;
    lat = 1;
    nwe = 0;
    if (!f) begin
      nb   = 1 << sz;
      sh   = 8 * int'(a[1:0]);
      mask = (64'd1 << (8 * nb)) - 64'd1;
      old  = ref_mem[a[11:2]];
      if (w) begin
        ref_mem[a[11:2]] = (old & ~(mask[31:0] << sh)) |
                           ((wd & mask[31:0]) << sh);
        lat = (nb == 4) ? 2 : 4;
        nwe = 1;
      end else begin
        v = (old >> sh) & mask[31:0];
        if (sg && nb < 4 && v[8 * nb - 1]) v = v | ~mask[31:0];
        rd  = v;
        lat = 3;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        f;
    int          lat;
    int          nwe;
    logic [31:0] ma;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd, ma, old, erd, w_a;
    logic        f, ef, w, sg;
    logic [1:0]  sz;
    int          lat, nwe, elat, enwe, hold, we0, r;

    tbl[0]  = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,
                32'h8899AABB, 1'b0, 3, 0, 32'd5};
    tbl[1]  = '{1'b0, 2'd0, 1'b1, 32'h17,  32'h0,
                32'hFFFFFF88, 1'b0, 3, 0, 32'd5};
    tbl[2]  = '{1'b0, 2'd0, 1'b0, 32'h17,  32'h0,
                32'h00000088, 1'b0, 3, 0, 32'd5};
    tbl[3]  = '{1'b0, 2'd1, 1'b1, 32'h16,  32'h0,
                32'hFFFF8899, 1'b0, 3, 0, 32'd5};
    tbl[4]  = '{1'b1, 2'd0, 1'b0, 32'h15,  32'h5C,
                32'h0, 1'b0, 4, 1, 32'd5};
    tbl[5]  = '{1'b0, 2'd2, 1'b1, 32'h14,  32'h0,
                32'h88995CBB, 1'b0, 3, 0, 32'd5};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 32'hFFC, 32'hDEADBEEF,
                32'h0, 1'b0, 2, 1, 32'd1023};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0,
                32'hDEADBEEF, 1'b0, 3, 0, 32'd1023};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h3,   32'h0,
                32'h0, 1'b1, 1, 0, 32'd0};
    tbl[9]  = '{1'b1, 2'd2, 1'b0, 32'h6,   32'h12345678,
                32'h0, 1'b1, 1, 0, 32'd0};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0,
                32'h0, 1'b1, 1, 0, 32'd0};
    tbl[11] = '{1'b0, 2'd3, 1'b0, 32'h10,  32'h0,
                32'h0, 1'b1, 1, 0, 32'd0};

    for (int i = 0; i < 1024; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[5] = 32'h8899AABB;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_fault", 32'(resp_fault), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a,
             tbl[i].wd, 0, rd, f, lat, nwe, ma);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
      chk($sformatf("vec%0d_fault", i), 32'(f), 32'(tbl[i].f));
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
      chk($sformatf("vec%0d_we_pulses", i), nwe, tbl[i].nwe);
      if (!tbl[i].f)
        chk($sformatf("vec%0d_mem_address", i), ma, tbl[i].ma);
    end
    chk("mem5_after_store", mem[5], 32'h88995CBB);
    chk("mem1023_after_store", mem[1023], 32'hDEADBEEF);

    // Backpressure: response held for 5 cycles.
    do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 5,
           rd, f, lat, nwe, ma);
    chk("bp_rdata", rd, 32'h00008899);
    chk("bp_latency", lat, 3);

    // Reset lands during READ of a byte store.
    old = mem[5];
    we0 = we_total;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'h15;
    req_wdata = 32'h11;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready_low", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    chk("midrst_no_write", we_total - we0, 32'd0);
    chk("midrst_mem5", mem[5], old);

    for (int i = 0; i < 16; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
      mem[1008 + i] = $urandom;
      ref_mem[1008 + i] = mem[1008 + i];
    end

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) w_a = $urandom_range(0, 63);
      else if (r < 9) w_a = $urandom_range(32'hFF0, 32'h1003);
      else w_a = $urandom;
      w    = 1'($urandom);
      sz   = 2'($urandom);
      sg   = 1'($urandom);
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      erd  = $urandom;
      do_req(w, sz, sg, w_a, erd, hold, rd, f, lat, nwe, ma);
      model(w, sz, sg, w_a, erd, erd, ef, elat, enwe);
      chk($sformatf("rnd%0d_rdata", i), rd, erd);
      chk($sformatf("rnd%0d_fault", i), 32'(f), 32'(ef));
      chk($sformatf("rnd%0d_latency", i), lat, elat);
      chk($sformatf("rnd%0d_we", i), nwe, enwe);
      if (!ef) begin
        chk($sformatf("rnd%0d_maddr", i), ma, {22'd0, w_a[11:2]});
        if (w)
          chk($sformatf("rnd%0d_memword", i),
              mem[w_a[11:2]], ref_mem[w_a[11:2]]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
